// File: rtl/fetch_stage_controller.sv
// Fetch stage: owns the PC and the IF/ID register. It handles hold requests
// and branch redirects that squash the pipeline.
module fetch_stage_controller #(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter logic [15:0] NOP_INST      = 16'h0000,
    parameter int unsigned SQUASH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_data,
    output logic [15:0] pc,
    output logic        pcwrite,
    output logic [15:0] ifid_inst,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
    output logic [1:0]  fetch_state,
    output logic [7:0]  stall_count,
    output logic [7:0]  flush_count
);

    // Handshake: stall is a level-sensitive advance enable (1 = advance,
    // 0 = hold). branch_taken overrides it in every state, and pcwrite tells
    // upstream in the same cycle whether pc changes at the coming edge.

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    localparam logic [3:0] SQUASH_LOAD = 4'(SQUASH_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  squash_q, squash_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic [7:0]  flush_cnt_q, flush_cnt_d;

    always_comb begin
        state_d     = state_q;
        squash_d    = squash_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        ipc_d       = ipc_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (branch_taken) begin
            // A redirect wins over a simultaneous hold request.
            pc_d     = branch_target;
            inst_d   = NOP_INST;
            valid_d  = 1'b0;
            state_d  = ST_SQUASH;
            squash_d = SQUASH_LOAD;
            if (flush_cnt_q != 8'hFF) begin
                flush_cnt_d = flush_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_SQUASH: begin
                    // Bubbles stay in IF/ID. Leave when the count runs out.
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    if (squash_q <= 4'd1) begin
                        squash_d = 4'd0;
                        state_d  = ST_RUN;
                    end else begin
                        squash_d = squash_q - 4'd1;
                    end
                end
                default: begin
                    if (!stall) begin
                        state_d = ST_HOLD;
                        if (stall_cnt_q != 8'hFF) begin
                            stall_cnt_d = stall_cnt_q + 8'd1;
                        end
                    end else begin
                        inst_d  = imem_data;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 16'd1;
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pcwrite = branch_taken | ((state_q != ST_SQUASH) & stall);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            squash_q    <= 4'd0;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            ipc_q       <= 16'h0000;
            valid_q     <= 1'b0;
            stall_cnt_q <= 8'h00;
            flush_cnt_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            ipc_q       <= ipc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign ifid_inst   = inst_q;
    assign ifid_pc     = ipc_q;
    assign ifid_valid  = valid_q;
    assign fetch_state = state_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage_controller.sv
// Bench for fetch_stage_controller: directed vectors with literal checks,
// plus a behavioural model that is compared against every output on each falling edge.
module tb_fetch_stage_controller;

    localparam logic [15:0] NOP    = 16'hF00D;
    localparam int          SQ     = 2;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b1;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_data;
    logic [15:0] pc;
    logic        pcwrite;
    logic [15:0] ifid_inst;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic [1:0]  fetch_state;
    logic [7:0]  stall_count;
    logic [7:0]  flush_count;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_stage_controller #(
        .RESET_PC(RST_PC),
        .NOP_INST(NOP),
        .SQUASH_CYCLES(SQ)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_data(imem_data),
        .pc(pc),
        .pcwrite(pcwrite),
        .ifid_inst(ifid_inst),
        .ifid_pc(ifid_pc),
        .ifid_valid(ifid_valid),
        .fetch_state(fetch_state),
        .stall_count(stall_count),
        .flush_count(flush_count)
    );

    // Instruction memory: word at address a is 16'hA000 + a.
    assign imem_data = 16'hA000 + pc;

    always #5 clock = ~clock;

    // Behavioural model: pending bubbles and a held flag stand in for the state.
    logic [15:0] m_pc = RST_PC, m_inst = NOP, m_ipc = 16'h0000;
    logic        m_valid = 1'b0, m_held = 1'b0;
    int          m_bubbles = 0, m_sc = 0, m_fc = 0;

    function automatic int sat_inc(int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_pc = RST_PC; m_inst = NOP; m_ipc = 16'h0000; m_valid = 1'b0;
            m_held = 1'b0; m_bubbles = 0; m_sc = 0; m_fc = 0;
        end else if (branch_taken) begin
            m_pc = branch_target; m_inst = NOP; m_valid = 1'b0;
            m_bubbles = SQ; m_held = 1'b0; m_fc = sat_inc(m_fc);
        end else if (m_bubbles > 0) begin
            m_bubbles = m_bubbles - 1;
        end else if (!stall) begin
            m_held = 1'b1; m_sc = sat_inc(m_sc);
        end else begin
            m_inst = 16'hA000 + m_pc; m_ipc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 16'd1; m_held = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [1:0] exp_state;
        exp_state = (m_bubbles > 0) ? 2'd2 : (m_held ? 2'd1 : 2'd0);
        chk("model_pc", pc, m_pc);
        chk("model_ifid_inst", ifid_inst, m_inst);
        chk("model_ifid_pc", ifid_pc, m_ipc);
        chk("model_ifid_valid", 16'(ifid_valid), 16'(m_valid));
        chk("model_fetch_state", 16'(fetch_state), 16'(exp_state));
        chk("model_stall_count", 16'(stall_count), 16'(m_sc));
        chk("model_flush_count", 16'(flush_count), 16'(m_fc));
        chk("model_pcwrite", 16'(pcwrite),
            16'(branch_taken | ((m_bubbles == 0) & stall)));
    end

    // One cycle: drive inputs, then sit 1 time unit past the next rising edge.
    task automatic apply(input logic s, input logic b, input logic [15:0] t);
        stall = s; branch_taken = b; branch_target = t;
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_pc", pc, RST_PC);
        chk("reset_inst", ifid_inst, NOP);
        chk("reset_valid", 16'(ifid_valid), 16'h0);
        chk("reset_pcwrite", 16'(pcwrite), 16'h1);
        reset_n = 1'b1;

        // Three straight fetches.
        repeat (3) apply(1'b1, 1'b0, 16'h0);
        chk("fetch3_pc", pc, 16'd3);
        chk("fetch3_inst", ifid_inst, 16'hA002);
        chk("fetch3_ipc", ifid_pc, 16'd2);
        chk("fetch3_valid", 16'(ifid_valid), 16'h1);

        // Hold for four edges at pc=5, then resume.
        repeat (2) apply(1'b1, 1'b0, 16'h0);
        repeat (4) apply(1'b0, 1'b0, 16'hBEEF);
        chk("hold_pc", pc, 16'd5);
        chk("hold_state", 16'(fetch_state), 16'd1);
        chk("hold_count", 16'(stall_count), 16'd4);
        chk("hold_inst", ifid_inst, 16'hA004);
        apply(1'b1, 1'b0, 16'h0);
        chk("resume_pc", pc, 16'd6);
        chk("resume_state", 16'(fetch_state), 16'd0);

        // Redirect together with a hold request, then two squash edges.
        apply(1'b0, 1'b1, 16'h0040);
        chk("br_pc", pc, 16'h0040);
        chk("br_valid", 16'(ifid_valid), 16'h0);
        chk("br_inst", ifid_inst, NOP);
        chk("br_flush", 16'(flush_count), 16'd1);
        apply(1'b0, 1'b0, 16'h1234);
        chk("sq1_state", 16'(fetch_state), 16'd2);
        apply(1'b0, 1'b0, 16'h1234);
        chk("sq2_state", 16'(fetch_state), 16'd0);
        chk("sq2_pc", pc, 16'h0040);
        chk("sq2_stall_count", 16'(stall_count), 16'd4);
        apply(1'b1, 1'b0, 16'h0);
        chk("post_br_ipc", ifid_pc, 16'h0040);
        chk("post_br_valid", 16'(ifid_valid), 16'h1);

        // Redirect during squash restarts the bubble count.
        apply(1'b1, 1'b1, 16'h0100);
        apply(1'b1, 1'b1, 16'h0200);
        chk("rebr_pc", pc, 16'h0200);
        chk("rebr_flush", 16'(flush_count), 16'd3);
        apply(1'b1, 1'b0, 16'h0);
        chk("rebr_sq_state", 16'(fetch_state), 16'd2);
        apply(1'b1, 1'b0, 16'h0);
        chk("rebr_run_state", 16'(fetch_state), 16'd0);

        // PC wrap from 16'hFFFF.
        apply(1'b1, 1'b1, 16'hFFFF);
        repeat (2) apply(1'b1, 1'b0, 16'h0);
        apply(1'b1, 1'b0, 16'h0);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_ipc", ifid_pc, 16'hFFFF);
        chk("wrap_inst", ifid_inst, 16'h9FFF);

        // Counter saturation.
        repeat (300) apply(1'b0, 1'b0, 16'h0);
        chk("stall_sat", 16'(stall_count), 16'h00FF);
        repeat (260) apply(1'b1, 1'b1, 16'h0010);
        chk("flush_sat", 16'(flush_count), 16'h00FF);

        // Asynchronous reset between edges while squashing.
        apply(1'b1, 1'b0, 16'h0);
        apply(1'b1, 1'b1, 16'h0300);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_pc", pc, RST_PC);
        chk("areset_inst", ifid_inst, NOP);
        chk("areset_ipc", ifid_pc, 16'h0000);
        chk("areset_state", 16'(fetch_state), 16'd0);
        chk("areset_flush", 16'(flush_count), 16'd0);
        chk("areset_stall", 16'(stall_count), 16'd0);
        #3 reset_n = 1'b1;
        apply(1'b1, 1'b0, 16'h0);
        chk("after_rst_pc", pc, 16'd1);
        chk("after_rst_inst", ifid_inst, 16'hA000);
        chk("after_rst_valid", 16'(ifid_valid), 16'h1);
        repeat (3) apply(1'b1, 1'b0, 16'h0);

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
